// File: rtl/ctr_seq_pkg.sv
// Shared state encoding and direction constants for the counter sequencer.
package ctr_seq_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/updn_ctr_core.sv
// Synchronous-reset up/down counter; load has priority over enable.
module updn_ctr_core
    import ctr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (dir == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ctr_sequencer.sv
// Sequences an up/down counter through latched count passes with pause, abort
// and auto-reload; flags each terminal count and the end of the run.
module ctr_sequencer
    import ctr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RPT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    input  logic [RPT_W-1:0] repeat_n,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [RPT_W-1:0] pass_cnt
);

    state_e           state_q;
    logic             dir_q;
    logic             auto_q;
    logic [WIDTH-1:0] limit_q;
    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] pass_q;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] start_val;
    logic             at_term;
    logic             reload;
    logic             ctr_en;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_val;

    assign term_val  = (dir_q == DIR_DN) ? '0 : limit_q;
    assign start_val = (dir_q == DIR_DN) ? limit_q : '0;
    assign at_term   = (cnt == term_val);
    assign reload    = auto_q && (pass_q < rpt_q);

    // Abort reuses the core's load path to clear the count.
    always_comb begin
        ctr_en   = 1'b0;
        ctr_load = 1'b0;
        ctr_val  = start_val;
        case (state_q)
            ST_LOAD: begin
                ctr_load = 1'b1;
                if (abort) ctr_val = '0;
            end
            ST_RUN: begin
                if (abort) begin
                    ctr_load = 1'b1;
                    ctr_val  = '0;
                end else if (!pause) begin
                    if (!at_term)    ctr_en   = 1'b1;
                    else if (reload) ctr_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    ctr_load = 1'b1;
                    ctr_val  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            auto_q  <= 1'b0;
            limit_q <= '0;
            rpt_q   <= '0;
            pass_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        dir_q   <= dir;
                        auto_q  <= auto_reload;
                        limit_q <= limit;
                        rpt_q   <= repeat_n;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    pass_q  <= '0;
                    state_q <= abort ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (abort) begin
                        pass_q  <= '0;
                        state_q <= ST_IDLE;
                    end else if (pause) begin
                        state_q <= ST_HOLD;
                    end else if (at_term) begin
                        pass_q <= pass_q + RPT_W'(1);
                        if (!reload) state_q <= ST_DONE;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        pass_q  <= '0;
                        state_q <= ST_IDLE;
                    end else if (!pause) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    updn_ctr_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (ctr_en),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dir      (dir_q),
        .cnt      (cnt)
    );

    // tc is suppressed in the cycle a pause or abort takes effect.
    assign tc       = (state_q == ST_RUN) && at_term && !pause && !abort;
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign done     = (state_q == ST_DONE);
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_ctr_sequencer.sv
// Bench for ctr_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural run model.
module tb_ctr_sequencer;

    localparam int W = 4;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst, start, abort, pause, dir, auto_reload;
    logic [W-1:0] limit;
    logic [R-1:0] repeat_n;
    logic [W-1:0] cnt;
    logic         busy, tc, done;
    logic [R-1:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ctr_sequencer #(.WIDTH(W), .RPT_W(R)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .dir         (dir),
        .auto_reload (auto_reload),
        .limit       (limit),
        .repeat_n    (repeat_n),
        .cnt         (cnt),
        .busy        (busy),
        .tc          (tc),
        .done        (done),
        .pass_cnt    (pass_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is loading, counting, held or finishing; idle otherwise.
    bit m_loading, m_counting, m_held, m_fin;
    int m_cnt, m_pass, m_lim, m_rpt, m_term, m_sv;
    bit m_dir, m_auto;

    always @(negedge clk) begin
        m_term = m_dir ? 0 : m_lim;
        m_sv   = m_dir ? m_lim : 0;
        if (chk_en) begin
            chk("cnt", cnt, m_cnt);
            chk("pass_cnt", pass_cnt, m_pass);
            chk("busy", busy, m_loading || m_counting || m_held);
            chk("done", done, m_fin);
            chk("tc", tc, m_counting && m_cnt == m_term && !pause && !abort);
        end
        if (rst) begin
            {m_loading, m_counting, m_held, m_fin} = '0;
            m_cnt = 0; m_pass = 0; m_lim = 0; m_rpt = 0; m_dir = 0; m_auto = 0;
        end else if (!(m_loading || m_counting || m_held || m_fin)) begin
            if (start && !abort) begin
                m_dir = dir; m_auto = auto_reload; m_lim = limit; m_rpt = repeat_n;
                m_loading = 1;
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (abort) begin
            {m_loading, m_counting, m_held} = '0;
            m_cnt = 0; m_pass = 0;
        end else if (m_loading) begin
            m_loading = 0; m_counting = 1; m_cnt = m_sv; m_pass = 0;
        end else if (m_held) begin
            if (!pause) begin m_held = 0; m_counting = 1; end
        end else if (pause) begin
            m_counting = 0; m_held = 1;
        end else if (m_cnt == m_term) begin
            if (m_auto && m_pass < m_rpt) m_cnt = m_sv;
            else begin m_counting = 0; m_fin = 1; end
            m_pass = (m_pass + 1) % (1 << R);
        end else begin
            m_cnt = m_dir ? (m_cnt + (1 << W) - 1) % (1 << W) : (m_cnt + 1) % (1 << W);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit d, input int lim, input bit au, input int rp);
        start = 1; dir = d; limit = W'(lim); auto_reload = au; repeat_n = R'(rp);
        tick();
        start = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1;
            tick();
        end
        chk("idle_timeout", ok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int e3 [12] = '{0, 0, 0, 1, 2, 2, 2, 2, 2, 3, 4, 4};
        int tcn, dnn;
        rst = 1; start = 0; abort = 0; pause = 0; dir = 0; auto_reload = 0;
        limit = '0; repeat_n = '0;
        tick(); tick(); tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_cnt", cnt, 0); chk("rst_busy", busy, 0); chk("rst_pass", pass_cnt, 0);
        tick();
        rst = 0;
        tick();

        // 1: up, limit 5, single pass
        go(0, 5, 0, 3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 7) chk("t1_cnt", cnt, c - 2);
            chk("t1_tc", tc, c == 7);
            chk("t1_done", done, c == 8);
            chk("t1_busy", busy, c >= 1 && c <= 7);
            if (c == 8) begin chk("t1_pass", pass_cnt, 1); chk("t1_cnt_done", cnt, 5); end
            tick();
        end
        wait_idle();

        // 2: down, limit 3, two reloads back to back
        go(1, 3, 1, 2);
        tcn = 0; dnn = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            tcn += int'(tc); dnn += int'(done);
            chk("t2_tc", tc, c == 5 || c == 9 || c == 13);
            if (c >= 2 && c <= 13) chk("t2_cnt", cnt, 3 - ((c - 2) % 4));
            if (c == 14) chk("t2_pass", pass_cnt, 3);
            tick();
        end
        chk("t2_tc_total", tcn, 3); chk("t2_done_total", dnn, 1);
        wait_idle();

        // 3: pause for three cycles at cnt=2
        go(0, 4, 0, 0);
        for (int c = 1; c <= 11; c++) begin
            pause = (c >= 4 && c <= 6);
            @(negedge clk);
            if (c >= 2) chk("t3_cnt", cnt, e3[c]);
            chk("t3_tc", tc, c == 10);
            chk("t3_done", done, c == 11);
            tick();
        end
        pause = 0;
        wait_idle();

        // 4: abort mid-run, then restart
        go(0, 7, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            abort = (c == 5);
            @(negedge clk);
            chk("t4_tc", tc, 0); chk("t4_done", done, 0);
            if (c == 5) chk("t4_cnt", cnt, 3);
            tick();
        end
        abort = 0;
        @(negedge clk);
        chk("t4_abort_cnt", cnt, 0); chk("t4_abort_busy", busy, 0);
        chk("t4_abort_pass", pass_cnt, 0); chk("t4_abort_done", done, 0);
        tick();
        go(0, 2, 0, 0);
        wait_idle();
        @(negedge clk);
        chk("t4_re_cnt", cnt, 2); chk("t4_re_pass", pass_cnt, 1);
        tick();

        // 5: limit 0 with one reload
        go(0, 0, 1, 1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t5_tc", tc, c == 2 || c == 3);
            chk("t5_done", done, c == 4);
            if (c == 4) chk("t5_pass", pass_cnt, 2);
            tick();
        end
        wait_idle();

        // 6: reset mid-run with start held
        start = 1; dir = 0; limit = 4'd6; auto_reload = 0;
        for (int c = 1; c <= 4; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("t6_cnt", cnt, 0); chk("t6_busy", busy, 0); chk("t6_tc", tc, 0);
        chk("t6_done", done, 0); chk("t6_pass", pass_cnt, 0);
        tick();
        start = 0;
        @(negedge clk);
        chk("t6_restart_busy", busy, 1);
        tick();
        wait_idle();

        // 7: start pulse during RUN is ignored
        go(0, 3, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            start = (c == 3);
            @(negedge clk);
            chk("t7_done", done, c == 6);
            chk("t7_busy", busy, c >= 1 && c <= 5);
            if (c == 6) chk("t7_cnt", cnt, 3);
            tick();
        end
        start = 0;

        // 8: start with abort in IDLE
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        @(negedge clk);
        chk("t8_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("t8_busy2", busy, 0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 29) == 0);
            pause       = ($urandom_range(0, 5) == 0);
            dir         = 1'($urandom);
            auto_reload = 1'($urandom);
            limit       = W'($urandom_range(0, 15));
            repeat_n    = R'($urandom_range(0, 7));
            tick();
        end
        rst = 0; start = 0; abort = 0; pause = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
